// File: rtl/mmu_pkg.sv
// Shared MMU types: host memory opcodes, arbiter FSM states and requester encodings.
package mmu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b11
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } arb_state_t;

   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between the I/D requesters, the host memory port and the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32
);
   import mmu_pkg::*;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [2:0]        i_trd;
   logic              i_done;
   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [2:0]        d_trd;
   logic              d_done;
   logic              ready;
   logic              tx_done;
   mem_op_t           mem_op;
   logic [ADDR_W-1:0] mem_addr;
   logic [2:0]        mem_trd;
   logic              mem_src;
   logic              timeout;

   // master: requesters plus host controller; slave: the arbiter itself
   modport master (
      output i_req, i_addr, i_trd, d_req, d_wr, d_addr, d_trd, ready, tx_done,
      input  i_done, d_done, mem_op, mem_addr, mem_trd, mem_src, timeout
   );

   modport slave (
      input  i_req, i_addr, i_trd, d_req, d_wr, d_addr, d_trd, ready, tx_done,
      output i_done, d_done, mem_op, mem_addr, mem_trd, mem_src, timeout
   );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving the I-fill and D-fill/write-back paths one-at-a-time
// access to the host memory port, with a WAIT-phase abort timer.
module mem_arbiter
   import mmu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   arb_state_t        state_q, state_d;
   mem_op_t           mem_op_q, mem_op_d;
   mem_op_t           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        trd_q, trd_d;
   logic              src_q, src_d;
   logic              last_q, last_d;
   logic              i_done_q, i_done_d;
   logic              d_done_q, d_done_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic grant;
   logic grant_src;
   logic abort;

   // A tie goes to whichever side did not own the previous transaction
   assign grant     = bus.i_req | bus.d_req;
   assign grant_src = (bus.i_req & bus.d_req) ? ~last_q : bus.d_req;
   assign abort     = (cnt_q == CNT_MAX) & ~bus.tx_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         mem_op_q  <= IDLE;
         op_q      <= IDLE;
         addr_q    <= '0;
         trd_q     <= '0;
         src_q     <= SRC_I;
         last_q    <= SRC_I;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mem_op_q  <= mem_op_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         trd_q     <= trd_d;
         src_q     <= src_d;
         last_q    <= last_d;
         i_done_q  <= i_done_d;
         d_done_q  <= d_done_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant) state_d = ST_ISSUE;
         ST_ISSUE: if (bus.ready) state_d = ST_WAIT;
         ST_WAIT:  if (bus.tx_done || abort) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead so every port comes straight from a flop
   always_comb begin
      op_d      = op_q;
      addr_d    = addr_q;
      trd_d     = trd_q;
      src_d     = src_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      mem_op_d  = IDLE;
      i_done_d  = 1'b0;
      d_done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               src_d = grant_src;
               if (grant_src == SRC_D) begin
                  addr_d = bus.d_addr;
                  trd_d  = bus.d_trd;
                  op_d   = bus.d_wr ? WRITE : READ;
               end else begin
                  addr_d = bus.i_addr;
                  trd_d  = bus.i_trd;
                  op_d   = READ;
               end
               mem_op_d = op_d;
            end
         end
         ST_ISSUE: begin
            if (bus.ready) cnt_d = '0;
            else           mem_op_d = op_q;
         end
         ST_WAIT: begin
            if (bus.tx_done || abort) begin
               timeout_d = timeout_q | abort;
               i_done_d  = (src_q == SRC_I);
               d_done_d  = (src_q == SRC_D);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: last_d = src_q;
         default: ;
      endcase
   end

   assign bus.mem_op   = mem_op_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_trd  = trd_q;
   assign bus.mem_src  = src_q;
   assign bus.i_done   = i_done_q;
   assign bus.d_done   = d_done_q;
   assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-timeline model of the arbitration and latency rules.
module tb_mem_arbiter;
   import mmu_pkg::*;

   localparam int ADDR_W = 32;
   localparam int TMO    = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
   mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;

   // reference model state
   bit          last_m;
   bit          sticky_m;
   bit          ipend, dpend, dwr;
   logic [31:0] ia, da;
   logic [2:0]  it, dt;
   bit          win;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      bus.i_req  = ipend;
      bus.i_addr = ia;
      bus.i_trd  = it;
      bus.d_req  = dpend;
      bus.d_addr = da;
      bus.d_trd  = dt;
      bus.d_wr   = dwr;
   endtask

   task automatic chk_quiet(input string tag, input logic exp_to);
      check({tag, ".op"}, bus.mem_op, IDLE);
      check({tag, ".idone"}, bus.i_done, 1'b0);
      check({tag, ".ddone"}, bus.d_done, 1'b0);
      check({tag, ".tmo"}, bus.timeout, exp_to);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ipend = 0; dpend = 0;
      drive_reqs();
      bus.ready = 1'b0; bus.tx_done = 1'b0;
      @(negedge clk);
      check("rst.op", bus.mem_op, IDLE);
      check("rst.addr", bus.mem_addr, 0);
      check("rst.trd", bus.mem_trd, 0);
      check("rst.src", bus.mem_src, 0);
      check("rst.idone", bus.i_done, 0);
      check("rst.ddone", bus.d_done, 0);
      check("rst.tmo", bus.timeout, 0);
      rst_n    = 1'b1;
      last_m   = SRC_I;
      sticky_m = 1'b0;
   endtask

   // Idle cycles with no request; stray host strobes must change nothing
   task automatic gap(input int n);
      for (int g = 0; g < n; g++) begin
         @(negedge clk);
         chk_quiet("gap", sticky_m);
         bus.ready   = 1'($urandom_range(0, 1));
         bus.tx_done = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk_quiet("gap.end", sticky_m);
      bus.ready = 1'b0; bus.tx_done = 1'b0;
   endtask

   // One transaction: IDLE grant, r stalled ISSUE cycles, tx_done at WAIT index t
   // (t > TMO means never), then DONE. Entered just before the IDLE cycle.
   task automatic run_one(input int r, input int t, input bit stray, input bit hold,
                          output bit w_o);
      mem_op_t     eop;
      logic [31:0] eaddr;
      logic [2:0]  etrd;
      bit          ab;
      int          wend;
      w_o   = (ipend && dpend) ? !last_m : dpend;
      eop   = (w_o && dwr) ? WRITE : READ;
      eaddr = w_o ? da : ia;
      etrd  = w_o ? dt : it;
      ab    = (t > TMO);
      wend  = ab ? TMO : t;

      @(negedge clk);
      chk_quiet("idle", sticky_m);
      drive_reqs();
      bus.ready = stray; bus.tx_done = stray;

      for (int c = 0; c <= r; c++) begin
         @(negedge clk);
         check("iss.op", bus.mem_op, eop);
         check("iss.addr", bus.mem_addr, eaddr);
         check("iss.trd", bus.mem_trd, etrd);
         check("iss.src", bus.mem_src, w_o);
         check("iss.idone", bus.i_done, 0);
         check("iss.ddone", bus.d_done, 0);
         check("iss.tmo", bus.timeout, sticky_m);
         bus.ready   = (c == r);
         bus.tx_done = stray && (c == 0);
      end

      for (int w = 0; w <= wend; w++) begin
         @(negedge clk);
         chk_quiet("wait", sticky_m);
         check("wait.src", bus.mem_src, w_o);
         bus.ready   = stray && (w == 0);
         bus.tx_done = (w == t);
      end

      @(negedge clk);
      check("done.op", bus.mem_op, IDLE);
      check("done.idone", bus.i_done, !w_o);
      check("done.ddone", bus.d_done, w_o);
      check("done.tmo", bus.timeout, sticky_m | ab);
      check("done.addr", bus.mem_addr, eaddr);
      sticky_m = sticky_m | ab;
      last_m   = w_o;
      bus.ready = 1'b0; bus.tx_done = 1'b0;
      if (!hold) begin
         if (w_o) dpend = 0;
         else     ipend = 0;
      end
      drive_reqs();
   endtask

   initial begin
      rst_n = 1'b0;
      ia = '0; da = '0; it = '0; dt = '0; dwr = 0;
      do_reset();

      // single I fill, tx_done 4 cycles after issue
      ipend = 1; ia = 32'h0001_0040; it = 3'd3;
      run_one(0, 3, 0, 0, win);

      // D write-back with ready held low for 5 cycles
      dpend = 1; da = 32'h0001_0280; dt = 3'd5; dwr = 1;
      run_one(5, 2, 0, 0, win);

      // both requesting from reset, held: D, I, D, I
      do_reset();
      ipend = 1; ia = 32'h0000_1111; it = 3'd1;
      dpend = 1; da = 32'h0000_2222; dt = 3'd6; dwr = 0;
      for (int k = 0; k < 4; k++) run_one(0, 1, 0, 1, win);
      ipend = 0; dpend = 0;
      drive_reqs();
      gap(2);

      // stray tx_done in IDLE/ISSUE and stray ready in WAIT
      ipend = 1; ia = 32'hCAFE_0000; it = 3'd2;
      run_one(2, 3, 1, 0, win);
      dpend = 1; da = 32'hBEEF_0010; dt = 3'd7; dwr = 1;
      run_one(0, 0, 1, 0, win);

      // timeout abort, then sticky flag through a normal transaction
      ipend = 1; ia = 32'h0000_0400; it = 3'd4;
      run_one(1, 99, 0, 0, win);
      dpend = 1; da = 32'h0000_0800; dt = 3'd0; dwr = 0;
      run_one(0, 1, 0, 0, win);

      // reset while in WAIT: no completion, timeout cleared
      ipend = 1; ia = 32'h0000_5A5A; it = 3'd5;
      @(negedge clk); chk_quiet("rw.idle", sticky_m); drive_reqs();
      @(negedge clk); check("rw.op", bus.mem_op, READ); bus.ready = 1'b1;
      @(negedge clk); chk_quiet("rw.w0", sticky_m); bus.ready = 1'b0;
      @(negedge clk); chk_quiet("rw.w1", sticky_m);
      rst_n = 1'b0;
      #1;
      check("rw.rst.op", bus.mem_op, IDLE);
      check("rw.rst.idone", bus.i_done, 0);
      check("rw.rst.tmo", bus.timeout, 0);
      ipend = 0; drive_reqs();
      last_m = SRC_I; sticky_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); chk_quiet("rw.post", 1'b0);
      end
      ipend = 1; ia = 32'h0000_7777; it = 3'd6;
      run_one(0, 2, 0, 0, win);

      // random traffic
      for (int n = 0; n < 150; n++) begin
         if (!ipend && !dpend && $urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
         if (!ipend && $urandom_range(0, 1) == 1) begin
            ipend = 1; ia = $urandom; it = 3'($urandom_range(0, 7));
         end
         if (!dpend && $urandom_range(0, 1) == 1) begin
            dpend = 1; da = $urandom; dt = 3'($urandom_range(0, 7)); dwr = 1'($urandom_range(0, 1));
         end
         if (!ipend && !dpend) begin
            ipend = 1; ia = $urandom; it = 3'($urandom_range(0, 7));
         end
         run_one($urandom_range(0, 4), $urandom_range(0, TMO + 2),
                 1'($urandom_range(0, 1)), 0, win);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates host-memory access between the instruction-side fill path and the data-side fill/write-back path of the MMU. It drives the single host memory controller port (mem_op/ready/tx_done), one transaction at a time. Simultaneous requests are resolved round-robin. The block sits between the MMU cache controller and the host interface. It latches each granted request's address and thread ID, and signals completion back to the originator.

## Interface
- ADDR_W, 32, address width of requests and mem_addr
- TIMEOUT, 1023, max cycles in WAIT before the transaction is aborted; legal range 1..65535
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- i_req  in  1  instruction-side line-fill request (read only); held until i_done
- i_addr  in  ADDR_W  instruction fill address; stable while i_req=1
- i_trd  in  3  thread ID of instruction request
- i_done  out  1  one-cycle completion pulse to instruction side
- d_req  in  1  data-side request; held until d_done
- d_wr  in  1  1 = write-back, 0 = fill read; stable while d_req=1
- d_addr  in  ADDR_W  data address
- d_trd  in  3  thread ID of data request
- d_done  out  1  one-cycle completion pulse to data side
- ready  in  1  host ready to accept an operation
- tx_done  in  1  host finished the current read/write (one-cycle pulse)
- mem_op  out  2  00 IDLE, 01 READ, 11 WRITE; 10 never driven
- mem_addr  out  ADDR_W  latched address of the granted request
- mem_trd  out  3  latched thread ID of the granted request
- mem_src  out  1  owner of the current transaction: 0 = I, 1 = D
- timeout  out  1  sticky: a transaction exceeded TIMEOUT; cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the side not granted last (last_grant register).
  - On grant: latch addr, trd and op (I → READ; D → d_wr ? WRITE : READ), set mem_src, go to ISSUE.
- ISSUE:
  - mem_op = latched op.
  - ready=1: the operation is accepted that cycle; go to WAIT. Otherwise stay. ISSUE has no timeout.
- WAIT:
  - mem_op = IDLE. Counter increments every cycle.
  - tx_done=1: go to DONE.
  - Counter reaches TIMEOUT with no tx_done: set timeout, go to DONE (abort).
- DONE:
  - Pulse i_done or d_done, per mem_src, for exactly one cycle.
  - Update last_grant := mem_src. Go to IDLE.
- Requester contract: deassert req in the cycle after done. The arbiter never samples req in DONE, so no spurious regrant occurs.
- tx_done seen outside WAIT is ignored. ready seen outside ISSUE is ignored.
- Requests change only through IDLE. Inputs of the granted side are not re-sampled after grant.
- Counter: width clog2(TIMEOUT+1); cleared on entry to WAIT; never wraps.

## Timing
- Reset values:
  - State IDLE; mem_op=00; mem_addr=0; mem_trd=0; mem_src=0.
  - i_done=0; d_done=0; timeout=0.
  - last_grant=I, so D wins the first tie.
- All outputs are registered.
- Latency example: req high at cycle 0 (IDLE) → mem_op valid at cycle 1 (ISSUE) → with ready=1 at cycle 1, WAIT from cycle 2 → tx_done at cycle k → done pulse at cycle k+1 → IDLE at cycle k+2.
- Best case, tx_done at cycle 2: done at cycle 3; next grant evaluated at cycle 4; mem_op at cycle 5.
- Timeout abort: done pulse exactly TIMEOUT+1 cycles after WAIT entry.
- Reset mid-operation: immediate return to IDLE with reset values. The in-flight transaction gets no done pulse.

## Structure
- Package mmu_pkg holds:
  - mem_op_t enum: IDLE=2'b00, READ=2'b01, WRITE=2'b11.
  - arb_state_t enum.
  - Source encodings SRC_I=1'b0, SRC_D=1'b1.
- MMU and cache_ctrl import the same mem_op_t.
- The 2-way round-robin and the timeout counter are small; keep them inline, no sub-module.

## Test plan
- Single I request, addr 0x00010040, trd 3, ready=1, tx_done 4 cycles after issue → mem_op=01, mem_addr=0x00010040, mem_trd=3 for one cycle; i_done pulse one cycle after tx_done; d_done stays 0.
- D write-back, d_wr=1, addr 0x00010280, ready low for 5 cycles → mem_op=11 held 6 cycles; WAIT entered on the cycle after ready rises.
- Both requesting from reset, each held high after its done → grants alternate D, I, D, I; mem_src toggles; no side is granted twice in a row.
- tx_done pulse while in IDLE or ISSUE, and ready pulse while in WAIT → ignored; no state change, no done pulse.
- TIMEOUT=8, tx_done never asserted → timeout=1 and the requester's done pulses 9 cycles after WAIT entry; timeout stays 1 through later normal transactions until rst_n.
- rst_n asserted during WAIT → mem_op=00, no done pulse, timeout=0; a request after reset release is granted normally.
